instr_reg_exec: RTL and testbench

//  Responder side of the instruction-register interface: 32-entry register file that

---
 rtl/instr_reg_exec.sv | 176 +++++++++++++++++
 tb/tb_instr_reg_exec.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_reg_exec.sv
// Instruction-register responder: 32-entry file of {opcode, a, b, result} with a
// single-cycle ALU for simple ops and a restoring divider for DIV/MOD.
module instr_reg_exec #(
    parameter int OP_W  = 32,
    parameter int RES_W = 64,
    parameter int DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load_en,
    input  logic [3:0]                    opcode,
    input  logic [OP_W-1:0]               operand_a,
    input  logic [OP_W-1:0]               operand_b,
    input  logic [$clog2(DEPTH)-1:0]      write_pointer,
    input  logic [$clog2(DEPTH)-1:0]      read_pointer,
    output logic                          ready,
    output logic                          wr_drop,
    output logic [4+2*OP_W+RES_W-1:0]     instruction_word,
    output logic                          rd_pending
);
    // state  | meaning
    // S_IDLE | accepting writes, divider idle
    // S_DIV  | one restoring-division quotient bit per cycle
    // S_WB   | sign-correct quotient/remainder, write back, clear pending

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(OP_W);

    typedef enum logic [3:0] {
        OP_ZERO  = 4'd0,
        OP_PASSA = 4'd1,
        OP_PASSB = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MULT  = 4'd5,
        OP_DIV   = 4'd6,
        OP_MOD   = 4'd7
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_WB
    } state_t;

    logic [3:0]       ent_opc [DEPTH];
    logic [OP_W-1:0]  ent_a   [DEPTH];
    logic [OP_W-1:0]  ent_b   [DEPTH];
    logic [RES_W-1:0] ent_res [DEPTH];
    logic [DEPTH-1:0] pending;

    state_t          state;
    logic [AW-1:0]   div_wp;
    logic            div_is_mod;
    logic            sign_a;
    logic            sign_b;
    logic [OP_W-1:0] divisor;
    logic [OP_W-1:0] quot;
    logic [OP_W-1:0] rem;
    logic [CW-1:0]   count;

    opcode_t          op_in;
    logic             accept;
    logic             is_divmod;
    logic [RES_W-1:0] ext_a;
    logic [RES_W-1:0] ext_b;
    logic [RES_W-1:0] simple_res;
    logic [OP_W-1:0]  mag_a;
    logic [OP_W-1:0]  mag_b;
    logic [OP_W:0]    trial;
    logic [OP_W:0]    diff;
    logic             fits;
    logic [RES_W-1:0] wb_mag;
    logic             wb_neg;
    logic [RES_W-1:0] wb_res;

    assign op_in     = opcode_t'(opcode);
    assign accept    = load_en && ready;
    assign is_divmod = (op_in == OP_DIV) || (op_in == OP_MOD);

    assign ext_a = {{(RES_W-OP_W){operand_a[OP_W-1]}}, operand_a};
    assign ext_b = {{(RES_W-OP_W){operand_b[OP_W-1]}}, operand_b};

    always_comb begin
        simple_res = '0;
        case (op_in)
            OP_PASSA: simple_res = ext_a;
            OP_PASSB: simple_res = ext_b;
            OP_ADD:   simple_res = ext_a + ext_b;
            OP_SUB:   simple_res = ext_a - ext_b;
            OP_MULT:  simple_res = RES_W'($signed(ext_a) * $signed(ext_b));
            default:  simple_res = '0;
        endcase
    end

    // Magnitudes are unsigned, so |-2^(OP_W-1)| is representable.
    assign mag_a = operand_a[OP_W-1] ? (~operand_a + 1'b1) : operand_a;
    assign mag_b = operand_b[OP_W-1] ? (~operand_b + 1'b1) : operand_b;

    // rem < divisor always, so a borrow out of diff means the trial does not fit.
    assign trial = {rem, quot[OP_W-1]};
    assign diff  = trial - {1'b0, divisor};
    assign fits  = ~diff[OP_W];

    assign wb_mag = div_is_mod ? {{(RES_W-OP_W){1'b0}}, rem} : {{(RES_W-OP_W){1'b0}}, quot};
    assign wb_neg = div_is_mod ? sign_a : (sign_a ^ sign_b);
    assign wb_res = wb_neg ? (~wb_mag + 1'b1) : wb_mag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_opc[i] <= '0;
                ent_a[i]   <= '0;
                ent_b[i]   <= '0;
                ent_res[i] <= '0;
            end
            pending    <= '0;
            state      <= S_IDLE;
            ready      <= 1'b1;
            wr_drop    <= 1'b0;
            div_wp     <= '0;
            div_is_mod <= 1'b0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            divisor    <= '0;
            quot       <= '0;
            rem        <= '0;
            count      <= '0;
        end else begin
            wr_drop <= load_en && !ready;

            if (accept) begin
                ent_opc[write_pointer] <= opcode;
                ent_a[write_pointer]   <= operand_a;
                ent_b[write_pointer]   <= operand_b;
                ent_res[write_pointer] <= is_divmod ? '0 : simple_res;
                if (is_divmod) begin
                    pending[write_pointer] <= 1'b1;
                    ready      <= 1'b0;
                    div_wp     <= write_pointer;
                    div_is_mod <= (op_in == OP_MOD);
                    sign_a     <= operand_a[OP_W-1];
                    sign_b     <= operand_b[OP_W-1];
                    divisor    <= mag_b;
                    rem        <= '0;
                    count      <= '0;
                    // Divide-by-zero leaves quot/rem at zero and skips the iterations.
                    quot       <= (operand_b == '0) ? '0 : mag_a;
                    state      <= (operand_b == '0) ? S_WB : S_DIV;
                end
            end

            case (state)
                S_DIV: begin
                    rem   <= fits ? diff[OP_W-1:0] : trial[OP_W-1:0];
                    quot  <= {quot[OP_W-2:0], fits};
                    count <= count + 1'b1;
                    if (count == CW'(OP_W-1))
                        state <= S_WB;
                end
                S_WB: begin
                    ent_res[div_wp] <= wb_res;
                    pending[div_wp] <= 1'b0;
                    ready           <= 1'b1;
                    state           <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign instruction_word = {ent_opc[read_pointer], ent_a[read_pointer],
                               ent_b[read_pointer], ent_res[read_pointer]};
    assign rd_pending = pending[read_pointer];

endmodule

// File: tb/tb_instr_reg_exec.sv
// Randomized self-checking bench for instr_reg_exec against an arithmetic
// reference model of the register file.
module tb_instr_reg_exec;
    localparam int IW = 4 + 2*32 + 64;

    logic          clk;
    logic          reset_n;
    logic          load_en;
    logic [3:0]    opcode;
    logic [31:0]   operand_a;
    logic [31:0]   operand_b;
    logic [4:0]    write_pointer;
    logic [4:0]    read_pointer;
    logic          ready;
    logic          wr_drop;
    logic [IW-1:0] instruction_word;
    logic          rd_pending;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  m_opc  [32];
    logic [31:0] m_a    [32];
    logic [31:0] m_b    [32];
    longint      m_res  [32];
    bit          m_pend [32];

    instr_reg_exec dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_en          (load_en),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .ready            (ready),
        .wr_drop          (wr_drop),
        .instruction_word (instruction_word),
        .rd_pending       (rd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic longint ref_result(int op, logic [31:0] a, logic [31:0] b);
        longint la, lb;
        la = $signed(a);
        lb = $signed(b);
        case (op)
            1: return la;
            2: return lb;
            3: return la + lb;
            4: return la - lb;
            5: return la * lb;
            6: return (lb == 0) ? 0 : la / lb;
            7: return (lb == 0) ? 0 : la % lb;
            default: return 0;
        endcase
    endfunction

    function automatic logic [IW-1:0] exp_word(int ad);
        logic [63:0] r;
        r = m_pend[ad] ? 64'd0 : 64'(m_res[ad]);
        return {m_opc[ad], m_a[ad], m_b[ad], r};
    endfunction

    function automatic logic [31:0] rand_op32();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'(int'($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_opc[i] = '0; m_a[i] = '0; m_b[i] = '0; m_res[i] = 0; m_pend[i] = 0;
        end
    endtask

    task automatic model_accept(int op, logic [31:0] a, logic [31:0] b, int wp);
        m_opc[wp]  = 4'(op);
        m_a[wp]    = a;
        m_b[wp]    = b;
        m_res[wp]  = ref_result(op, a, b);
        m_pend[wp] = (op == 6 || op == 7);
    endtask

    task automatic drive(int op, logic [31:0] a, logic [31:0] b, int wp, int rp, logic en);
        opcode        = 4'(op);
        operand_a     = a;
        operand_b     = b;
        write_pointer = 5'(wp);
        read_pointer  = 5'(rp);
        load_en       = en;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1 || wr_drop !== 1'b0)
            $display("FAIL reset_flags: ready=%b wr_drop=%b expected 1 0", ready, wr_drop);
        if (ready !== 1'b1 || wr_drop !== 1'b0) n_fail++;
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            read_pointer = 5'(i);
            #1;
            n_checks++;
            if (instruction_word !== '0 || rd_pending !== 1'b0 || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: word=%h pend=%b ready=%b expected 0 0 1",
                         i, instruction_word, rd_pending, ready);
            end
        end
    endtask

    task automatic test_simple();
        @(posedge clk); #1;
        drive(3, -32'sd7, 32'sd12, 3, 3, 1'b1);
        #1;
        n_checks++;
        if (instruction_word !== exp_word(3)) begin
            n_fail++;
            $display("FAIL add_pre_read: got %h expected %h", instruction_word, exp_word(3));
        end
        @(posedge clk); #1;
        model_accept(3, -32'sd7, 32'sd12, 3);
        n_checks++;
        if (instruction_word[63:0] !== 64'd5 || instruction_word !== exp_word(3) || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_result: got %h ready=%b expected %h ready=1",
                     instruction_word, ready, exp_word(3));
        end
        drive(5, -32'sd15, 32'sd15, 4, 4, 1'b1);
        @(posedge clk); #1;
        model_accept(5, -32'sd15, 32'sd15, 4);
        n_checks++;
        if (instruction_word[63:0] !== 64'hFFFF_FFFF_FFFF_FF1F || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mult_result: got %h ready=%b expected ffffffffffffff1f ready=1",
                     instruction_word[63:0], ready);
        end
        read_pointer = 5'd3;
        #1;
        n_checks++;
        if (instruction_word !== exp_word(3)) begin
            n_fail++;
            $display("FAIL add_kept: got %h expected %h", instruction_word, exp_word(3));
        end
        for (int i = 0; i < 60; i++) begin
            int op, wp, rp;
            logic [31:0] a, b;
            op = $urandom_range(0, 5);
            a  = rand_op32();
            b  = rand_op32();
            wp = $urandom_range(0, 31);
            rp = (i % 3 == 0) ? int'($urandom_range(0, 31)) : wp;
            @(posedge clk); #1;
            drive(op, a, b, wp, rp, 1'b1);
            #1;
            n_checks++;
            if (instruction_word !== exp_word(rp)) begin
                n_fail++;
                $display("FAIL simple_pre_read[%0d]: got %h expected %h", i, instruction_word, exp_word(rp));
            end
            @(posedge clk); #1;
            model_accept(op, a, b, wp);
            n_checks++;
            if (instruction_word !== exp_word(rp) || ready !== 1'b1 || wr_drop !== 1'b0 || rd_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL simple_op[%0d] op=%0d: got %h ready=%b drop=%b expected %h ready=1 drop=0",
                         i, op, instruction_word, ready, wr_drop, exp_word(rp));
            end
            drive(op, a, b, wp, rp, 1'b0);
        end
    endtask

    task automatic run_divmod(int op, logic [31:0] a, logic [31:0] b, int wp);
        int lat, other;
        lat   = (b == 0) ? 1 : 33;
        other = (wp + 1) % 32;
        drive(op, a, b, wp, wp, 1'b1);
        @(posedge clk); #1;
        load_en = 1'b0;
        model_accept(op, a, b, wp);
        n_checks++;
        if (ready !== 1'b0 || rd_pending !== 1'b1 || instruction_word !== exp_word(wp)) begin
            n_fail++;
            $display("FAIL divmod_accept @%0d: ready=%b pend=%b word=%h expected 0 1 %h",
                     wp, ready, rd_pending, instruction_word, exp_word(wp));
        end
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == lat) m_pend[wp] = 0;
            read_pointer = ((k % 2 == 1) && k != lat) ? 5'(other) : 5'(wp);
            #1;
            n_checks++;
            if (ready !== 1'(k == lat) || rd_pending !== m_pend[read_pointer] ||
                instruction_word !== exp_word(int'(read_pointer))) begin
                n_fail++;
                $display("FAIL divmod_cycle %0d/%0d op=%0d a=%h b=%h rp=%0d: ready=%b pend=%b word=%h expected %b %b %h",
                         k, lat, op, a, b, read_pointer, ready, rd_pending, instruction_word,
                         (k == lat), m_pend[read_pointer], exp_word(int'(read_pointer)));
            end
        end
    endtask

    task automatic test_div();
        @(posedge clk); #1;
        run_divmod(6, -32'sd15, 32'sd4, 7);
        n_checks++;
        if (instruction_word[63:0] !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_m15_4: got %h expected fffffffffffffffd", instruction_word[63:0]);
        end
        run_divmod(7, -32'sd15, 32'sd4, 8);
        n_checks++;
        if (instruction_word[63:0] !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL mod_m15_4: got %h expected fffffffffffffffd", instruction_word[63:0]);
        end
        run_divmod(7, -32'sd15, -32'sd4, 9);
        n_checks++;
        if (instruction_word[63:0] !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL mod_m15_m4: got %h expected fffffffffffffffd", instruction_word[63:0]);
        end
        run_divmod(6, 32'h8000_0000, 32'hFFFF_FFFF, 20);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = rand_op32();
            b = rand_op32();
            if (b == 0) b = 32'd3;
            run_divmod(6 + int'($urandom_range(0, 1)), a, b, int'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_div_zero();
        @(posedge clk); #1;
        run_divmod(6, 32'sd9, 32'sd0, 12);
        run_divmod(7, 32'sd9, 32'sd0, 13);
        n_checks++;
        if (instruction_word[63:0] !== 64'd0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mod_by_zero: got %h ready=%b expected 0 ready=1", instruction_word[63:0], ready);
        end
        drive(3, 32'sd100, -32'sd1, 14, 14, 1'b1);
        @(posedge clk); #1;
        load_en = 1'b0;
        model_accept(3, 32'sd100, -32'sd1, 14);
        n_checks++;
        if (instruction_word !== exp_word(14)) begin
            n_fail++;
            $display("FAIL write_after_div0: got %h expected %h", instruction_word, exp_word(14));
        end
    endtask

    task automatic test_drop();
        logic [31:0] a, b, a2, b2;
        a  = rand_op32();
        b  = 32'd7;
        a2 = rand_op32();
        b2 = rand_op32();
        @(posedge clk); #1;
        drive(6, a, b, 10, 11, 1'b1);
        @(posedge clk); #1;
        model_accept(6, a, b, 10);
        n_checks++;
        if (wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_on_accept: wr_drop=%b expected 0", wr_drop);
        end
        drive(3, a2, b2, 11, 11, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            if (k == 33) m_pend[10] = 0;
            n_checks++;
            if (wr_drop !== 1'b1 || ready !== 1'(k == 33) || instruction_word !== exp_word(11)) begin
                n_fail++;
                $display("FAIL drop_cycle %0d: drop=%b ready=%b word=%h expected 1 %b %h",
                         k, wr_drop, ready, instruction_word, (k == 33), exp_word(11));
            end
        end
        @(posedge clk); #1;
        load_en = 1'b0;
        model_accept(3, a2, b2, 11);
        n_checks++;
        if (wr_drop !== 1'b0 || instruction_word !== exp_word(11)) begin
            n_fail++;
            $display("FAIL drop_then_land: drop=%b word=%h expected 0 %h", wr_drop, instruction_word, exp_word(11));
        end
        read_pointer = 5'd10;
        #1;
        n_checks++;
        if (instruction_word !== exp_word(10) || rd_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_div_result: word=%h pend=%b expected %h 0", instruction_word, rd_pending, exp_word(10));
        end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] a, b;
        @(posedge clk); #1;
        drive(6, -32'sd1000, 32'sd3, 7, 7, 1'b1);
        @(posedge clk); #1;
        load_en = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (ready !== 1'b1 || rd_pending !== 1'b0 || instruction_word !== '0 || wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_div: ready=%b pend=%b word=%h drop=%b expected 1 0 0 0",
                     ready, rd_pending, instruction_word, wr_drop);
        end
        for (int i = 0; i < 32; i++) begin
            read_pointer = 5'(i);
            #1;
            n_checks++;
            if (instruction_word !== '0 || rd_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_clear[%0d]: word=%h pend=%b expected 0 0", i, instruction_word, rd_pending);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        a = rand_op32();
        b = rand_op32();
        @(posedge clk); #1;
        drive(3, a, b, 5, 5, 1'b1);
        @(posedge clk); #1;
        load_en = 1'b0;
        model_accept(3, a, b, 5);
        n_checks++;
        if (instruction_word !== exp_word(5) || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_after_reset: word=%h ready=%b expected %h 1", instruction_word, ready, exp_word(5));
        end
        read_pointer = 5'd7;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ready !== 1'b1 || instruction_word !== '0 || rd_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL aborted_div_stays_clear %0d: ready=%b word=%h pend=%b expected 1 0 0",
                         k, ready, instruction_word, rd_pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_div();
        test_div_zero();
        test_drop();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
